// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath width, instruction field positions
// and the fetch-queue slot record.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } slot_t;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [XLEN-1:0] word);
        return word[OPCODE_LSB +: OPCODE_W];
    endfunction

    function automatic logic [FUNCT3_W-1:0] get_funct3(input logic [XLEN-1:0] word);
        return word[FUNCT3_LSB +: FUNCT3_W];
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect, and the
// head-of-queue hand-off to decode.
interface ifu_fetch_queue_if;
    import fetch_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_resp_valid;
    logic [XLEN-1:0]     imem_resp_data;

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    logic                inst_valid;
    logic                inst_ready;
    logic [XLEN-1:0]     inst;
    logic [XLEN-1:0]     inst_pc;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        output opcode,
        output funct3,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  opcode,
        input  funct3,
        output inst_ready
    );

endinterface

// File: rtl/ifq_ring.sv
// In-order slot ring for the fetch queue: slots are allocated at tail, filled
// in order at fill, and retired at head. Pointers carry a wrap bit.
module ifq_ring
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output slot_t           head_o,
    output logic [PtrW-1:0] occupied_o,
    output logic [PtrW-1:0] unfilled_o
);

    localparam int unsigned IdxW = PtrW - 1;

    slot_t           slots_q [Depth];
    slot_t           slots_d [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] fill_q, fill_d;
    logic [PtrW-1:0] tail_q, tail_d;

    logic [IdxW-1:0] head_idx, fill_idx, tail_idx;

    assign head_idx = head_q[IdxW-1:0];
    assign fill_idx = fill_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];

    always_comb begin
        slots_d = slots_q;
        head_d  = head_q;
        fill_d  = fill_q;
        tail_d  = tail_q;
        if (flush_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                slots_d[i].filled = 1'b0;
            end
            head_d = tail_q;
            fill_d = tail_q;
        end else begin
            // Alloc, fill and pop never target the same slot: credit keeps tail
            // off head, and fill/pop are separated by the filled flag.
            if (alloc_i) begin
                slots_d[tail_idx].pc     = alloc_pc_i;
                slots_d[tail_idx].filled = 1'b0;
                tail_d                   = tail_q + PtrW'(1);
            end
            if (fill_i) begin
                slots_d[fill_idx].data   = fill_data_i;
                slots_d[fill_idx].filled = 1'b1;
                fill_d                   = fill_q + PtrW'(1);
            end
            if (pop_i) begin
                // Cleared so an empty queue never shows a stale valid head.
                slots_d[head_idx].filled = 1'b0;
                head_d                   = head_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slots_q <= '{default: '0};
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
        end
    end

    assign head_o     = slots_q[head_idx];
    assign occupied_o = tail_q - head_q;
    assign unfilled_o = tail_q - fill_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation under a credit limit,
// in-order response queue, and redirect with in-flight response dropping.
module ifu_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    ifu_fetch_queue_if.master   bus_io
);

    localparam int unsigned     PtrW      = $clog2(DEPTH) + 1;
    localparam logic [PtrW:0]   CreditMax = (PtrW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PtrW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] occupied, unfilled, drain;
    logic [PtrW:0]   credit_used;
    logic            req_valid, req_fire;
    logic            resp_drop, resp_fill, pop;
    slot_t           head;

    // Credit covers both live slots and responses still owed from before a flush.
    assign credit_used = {1'b0, occupied} + {1'b0, drop_q};
    assign req_valid   = !rst && !bus_io.redirect_valid && (credit_used < CreditMax);
    assign req_fire    = req_valid && bus_io.imem_req_ready;

    assign resp_drop = bus_io.imem_resp_valid && (drop_q != '0);
    assign resp_fill = bus_io.imem_resp_valid && (drop_q == '0) && (unfilled != '0)
                       && !bus_io.redirect_valid;
    assign pop       = head.filled && bus_io.inst_ready;

    assign drain = drop_q + unfilled;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (bus_io.redirect_valid) begin
            pc_d = bus_io.redirect_pc;
            // A response arriving in the redirect cycle is already drained.
            if (bus_io.imem_resp_valid && (drain != '0)) begin
                drop_d = drain - PtrW'(1);
            end else begin
                drop_d = drain;
            end
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (resp_drop) begin
                drop_d = drop_q - PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    ifq_ring #(
        .Depth (DEPTH)
    ) u_ring (
        .clk_i       (clk),
        .rst_i       (rst),
        .alloc_i     (req_fire),
        .alloc_pc_i  (pc_q),
        .fill_i      (resp_fill),
        .fill_data_i (bus_io.imem_resp_data),
        .pop_i       (pop),
        .flush_i     (bus_io.redirect_valid),
        .head_o      (head),
        .occupied_o  (occupied),
        .unfilled_o  (unfilled)
    );

    assign bus_io.imem_req_valid = req_valid;
    assign bus_io.imem_req_addr  = pc_q;
    assign bus_io.inst_valid     = head.filled;
    assign bus_io.inst           = head.data;
    assign bus_io.inst_pc        = head.pc;
    assign bus_io.opcode         = get_opcode(head.data);
    assign bus_io.funct3         = get_funct3(head.data);

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: per-cycle vector table plus hand sequences, with a
// scoreboard of expected fetch addresses and instructions.
module tb_ifu_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned     DEPTH    = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct {
        bit              rst;
        bit              rdy;
        bit              irdy;
        bit              hold;
        bit              redir;
        logic [XLEN-1:0] rpc;
        bit              exp_req;
        bit              exp_inst;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold;
    int   n_checks;
    int   n_fails;

    logic [XLEN-1:0] mem_q[$];
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] exp_addr;
    vec_t            vecs[$];

    ifu_fetch_queue_if bus ();

    ifu_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] word_at(input logic [XLEN-1:0] a);
        return (a << 10) ^ 32'h0000_2083;
    endfunction

    function automatic vec_t mk(input bit r, input bit rdy, input bit irdy, input bit hd,
                                input bit rd, input logic [XLEN-1:0] rpc, input bit er,
                                input bit ei);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.irdy = irdy; v.hold = hd; v.redir = rd;
        v.rpc = rpc; v.exp_req = er; v.exp_inst = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input bit r, input bit rdy, input bit irdy, input bit hd,
                              input bit rd, input logic [XLEN-1:0] rpc);
        rst                    = r;
        hold                   = hd;
        bus.imem_req_ready     = rdy;
        bus.inst_ready         = irdy;
        bus.redirect_valid     = rd;
        bus.redirect_pc        = rpc;
        bus.imem_resp_valid    = !r && !hd && (mem_q.size() > 0);
        bus.imem_resp_data     = (mem_q.size() > 0) ? word_at(mem_q[0]) : '0;
    endtask

    // Settle at the falling edge and account for what the next rising edge commits.
    task automatic sample();
        logic [XLEN-1:0] e;
        @(negedge clk);
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_addr = RESET_PC;
            return;
        end
        if (bus.imem_resp_valid) void'(mem_q.pop_front());
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_addr);
            mem_q.push_back(bus.imem_req_addr);
            exp_q.push_back(exp_addr);
            exp_addr = exp_addr + 32'd4;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_inst: got pc %h expected none", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", bus.inst_pc, e);
                chk("inst", bus.inst, word_at(e));
                chk("opcode", {25'd0, bus.opcode}, {25'd0, get_opcode(word_at(e))});
                chk("funct3", {29'd0, bus.funct3}, {29'd0, get_funct3(word_at(e))});
            end
        end
        if (bus.redirect_valid) begin
            exp_q.delete();
            exp_addr = bus.redirect_pc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        chk({tag, "_inst"}, bus.inst, 32'd0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 32'd0);
        chk({tag, "_opcode"}, {25'd0, bus.opcode}, 32'd0);
        chk({tag, "_funct3"}, {29'd0, bus.funct3}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_addr = RESET_PC;
        hold     = 1'b0;

        // Full queue with inst_ready low, one pop, then refill.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        // imem_req_ready toggling while draining.
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
        // Redirect with two responses in flight.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        // Redirect with a response landing in the same cycle.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
        // Redirect on a full queue together with a head pop.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 32'h300, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));

        set_inputs(1, 0, 0, 0, 0, '0);
        sample();
        tick();
        set_inputs(1, 0, 0, 0, 0, '0);
        sample();
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        check_reset_outputs("rst");
        tick();

        // Streaming with 1-cycle memory and decode always ready.
        for (int i = 0; i < 6; i++) begin
            set_inputs(0, 1, 1, 0, 0, '0);
            sample();
            chk("stream_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("stream_inst_valid", {31'd0, bus.inst_valid}, (i >= 2) ? 32'd1 : 32'd0);
            if (i == 2) begin
                chk("first_inst", bus.inst, 32'h0000_2083);
                chk("first_opcode", {25'd0, bus.opcode}, 32'h03);
                chk("first_funct3", {29'd0, bus.funct3}, 32'h2);
            end
            tick();
        end

        foreach (vecs[k]) begin
            set_inputs(vecs[k].rst, vecs[k].rdy, vecs[k].irdy, vecs[k].hold,
                       vecs[k].redir, vecs[k].rpc);
            sample();
            chk($sformatf("vec%0d_req_valid", k), {31'd0, bus.imem_req_valid},
                {31'd0, vecs[k].exp_req});
            chk($sformatf("vec%0d_inst_valid", k), {31'd0, bus.inst_valid},
                {31'd0, vecs[k].exp_inst});
            tick();
        end

        // Reset mid-stream with responses still outstanding.
        for (int i = 0; i < 2; i++) begin
            set_inputs(0, 1, 0, 1, 0, '0);
            sample();
            tick();
        end
        set_inputs(1, 1, 0, 1, 0, '0);
        sample();
        chk("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        set_inputs(0, 1, 0, 0, 0, '0);
        sample();
        chk("postrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("postrst_req_addr", bus.imem_req_addr, RESET_PC);
        check_reset_outputs("postrst");
        tick();
        for (int j = 0; j < 4; j++) begin
            set_inputs(0, 1, 1, 0, 0, '0);
            sample();
            chk("restart_inst_valid", {31'd0, bus.inst_valid}, (j >= 1) ? 32'd1 : 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Instruction-fetch front end directly upstream of the opcode (7→128) and funct3 (3→8) one-hot decoders. Generates sequential PCs, issues requests to instruction memory under a credit limit, and reorders nothing. Returned words go into a DEPTH-entry in-order queue. The head instruction is presented to decode with its PC and pre-split opcode/funct3 fields. A redirect flushes the queue and discards responses still in flight.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, queue entries; also the max of queued plus in-flight instructions; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address (= pc register)
- imem_resp_valid  in  1  response valid, in request order, ≥1 cycle after acceptance
- imem_resp_data  in  XLEN  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch address, word-aligned
- inst_valid  out  1  head entry holds a returned instruction
- inst_ready  in  1  decode consumes head
- inst  out  XLEN  head instruction
- inst_pc  out  XLEN  head PC
- opcode  out  7  inst[6:0], to opcode decoder
- funct3  out  3  inst[14:12], to funct3 decoder

## Operation
- State: pc; ring of DEPTH slots {pc, data, filled}; pointers head (oldest), fill (oldest unfilled), tail (next alloc), each log2(DEPTH)+1 bits with wrap bit; drop_cnt, log2(DEPTH)+1 bits.
- occupied = tail − head; unfilled = tail − fill.
- Issue: imem_req_valid = !rst && !redirect_valid && (occupied + drop_cnt < DEPTH). On valid&&ready, allocate slot at tail with pc and filled=0; tail++ and pc += 4 (mod 2^XLEN; wrap is silent).
- Response: if drop_cnt>0, discard and decrement drop_cnt. Else if unfilled>0, write data into the slot at fill, set filled, and advance fill. Else ignore it (protocol violation).
- Output: inst_valid = slot[head].filled; inst, inst_pc, opcode, funct3 come from the head slot (driven even when not valid). On inst_valid&&inst_ready, head++.
- Redirect (highest priority on state):
  - pc ← redirect_pc.
  - head, fill, tail ← equal; all filled ← 0.
  - drop_cnt ← drop_cnt + unfilled − (imem_resp_valid ? 1 : 0); the same-cycle response counts as drained.
  - A head handshake in the redirect cycle still counts as consumed.
- Reset: pc = RESET_PC, pointers 0, drop_cnt 0, filled all 0. Consequently imem_req_valid = 0, inst_valid = 0, and inst/inst_pc/opcode/funct3 = 0.

## Timing
- The first request is asserted in the first cycle after rst deasserts, with addr RESET_PC.
- Response to inst_valid: 1 cycle (registered, no bypass).
- With 1-cycle memory and inst_ready held high:
  - request at cycle n, inst_valid at n+2;
  - sustained 1 instr/cycle requires DEPTH ≥ 3.
- Full (occupied+drop_cnt = DEPTH): imem_req_valid low until a head pop or a dropped response frees credit. The freed credit is visible the next cycle.
- Simultaneous push of the last unfilled slot and head pop: both take effect.
- Redirect cycle: no request issued. The first request at redirect_pc comes the next cycle if credit allows.
- Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.

## Structure
- Shared package fetch_pkg holds:
  - XLEN;
  - field positions OPCODE_LSB=0/OPCODE_W=7, FUNCT3_LSB=12/FUNCT3_W=3;
  - the slot struct {pc, data, filled}.
  The decoders and control unit import the same field constants.
- One sub-module, ifq_ring. It holds the slot storage and the three pointers, with alloc/fill/pop/flush ports. The top holds pc, drop_cnt, credit and the handshakes.

## Test plan
- Reset then stream, ready=1, 1-cycle memory, DEPTH=4. Expect requests at 0x0, 0x4, 0x8… on consecutive cycles, and inst_valid from cycle 2 onward with inst_pc matching. Response 0x00002083 → opcode 7'h03, funct3 3'h2.
- inst_ready=0, no stalls on memory: exactly 4 requests are accepted, then imem_req_valid stays low. After one pop, the next request comes the following cycle.
- imem_req_ready toggling 1/0: pc advances only on accepted cycles, and there are no duplicate or skipped addresses.
- Two requests in flight, then redirect to 0x100. The next two responses are dropped, and inst_pc then starts at 0x100 with no stale instruction. Repeat with a response landing in the redirect cycle: exactly one further response is dropped.
- Redirect while the queue is full and a head pop happens the same cycle: the pop is consumed once, the queue is empty next cycle, and the request is to redirect_pc.
- rst asserted mid-stream with two in flight: all outputs return to reset values next cycle, and the first request is at RESET_PC.
